// File: rtl/rah_tx_arbiter.sv
// Round-robin packet-locked arbiter in front of the rah_encoder write port.
// Ports: clk/rstn, app_en, req_valid/last/data -> req_ready; fifo_full -> wr_en/wr_data/wr_app_id, busy, burst_err.
module rah_tx_arbiter #(
  parameter int TOTAL_APPS       = 4,
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int MAX_BURST        = 64,
  parameter int ID_W = (TOTAL_APPS > 1) ? $clog2(TOTAL_APPS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [TOTAL_APPS-1:0]                app_en,
  input  logic [TOTAL_APPS-1:0]                req_valid,
  input  logic [TOTAL_APPS-1:0]                req_last,
  input  logic [TOTAL_APPS*RAH_PACKET_WIDTH-1:0] req_data,
  output logic [TOTAL_APPS-1:0]                req_ready,
  input  logic                                 fifo_full,
  output logic                                 wr_en,
  output logic [RAH_PACKET_WIDTH-1:0]          wr_data,
  output logic [ID_W-1:0]                      wr_app_id,
  output logic                                 busy,
  output logic                                 burst_err
);

  localparam int N  = TOTAL_APPS;
  localparam int W  = RAH_PACKET_WIDTH;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

  logic [0:0]      state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic [BW-1:0]   beat_cnt;

  logic [N-1:0]    cand;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] idx;
  logic            found;
  logic [ID_W-1:0] rr_nxt;
  logic [W-1:0]    sel_data;
  logic            xfer;
  logic            cut;
  logic            done;

  // First eligible app at or after rr_ptr, wrapping modulo N.
  always_comb begin
    cand  = req_valid & app_en;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(rr_ptr) + k >= N) ?
            ID_W'(int'(rr_ptr) + k - N) :
            ID_W'(int'(rr_ptr) + k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rr_nxt   = (grant == LAST_ID) ? '0 : grant + 1'b1;
  assign sel_data = req_data[int'(grant)*W +: W];

  assign xfer = (state == S_BURST) && req_valid[grant] && !fifo_full;
  assign cut  = xfer && !req_last[grant] && (beat_cnt == BEAT_MAX);
  assign done = xfer && (req_last[grant] || cut);

  // Ready only toward the locked app; IDLE leaves a one-cycle bubble.
  always_comb begin
    req_ready = '0;
    if (state == S_BURST && !fifo_full) req_ready[grant] = 1'b1;
  end

  assign busy = (state == S_BURST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_app_id <= '0;
      burst_err <= 1'b0;
    end else begin
      wr_en     <= xfer;
      burst_err <= cut;
      if (xfer) begin
        wr_data   <= sel_data;
        wr_app_id <= grant;
      end
      unique case (state)
        S_IDLE: begin
          if (found) begin
            grant    <= pick;
            beat_cnt <= '0;
            state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (done) begin
            state    <= S_IDLE;
            rr_ptr   <= rr_nxt;
            beat_cnt <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rah_tx_arbiter.sv
// Directed bench for rah_tx_arbiter with app source queues and a write scoreboard.
// Expected writes are queued in the order the round-robin rules predict.
module tb_rah_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 48;
  localparam int MB = 4;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
    logic          err;
  } exp_t;

  logic             clk;
  logic             rstn;
  logic [N-1:0]     app_en;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_last;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             fifo_full;
  logic             wr_en;
  logic [W-1:0]     wr_data;
  logic [IW-1:0]    wr_app_id;
  logic             busy;
  logic             burst_err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int tot_cnt  = 0;

  exp_t       sb[$];
  logic [W:0] src_q[N][$];
  logic       man;
  logic       track2, seen2;
  logic       track1, seen1;

  rah_tx_arbiter #(
    .TOTAL_APPS(N),
    .RAH_PACKET_WIDTH(W),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .app_en(app_en),
    .req_valid(req_valid),
    .req_last(req_last),
    .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_app_id(wr_app_id),
    .busy(busy),
    .burst_err(burst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int app, input int n);
    return {16'(16'hA0 + app), 32'(n)};
  endfunction

  task automatic push_src(input int app, input logic [W-1:0] d,
                          input logic last);
    src_q[app].push_back({last, d});
  endtask

  task automatic expect_wr(input int app, input logic [W-1:0] d,
                           input logic err);
    exp_t e;
    e.id   = IW'(app);
    e.data = d;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drain"}, 64'(k < 300), 64'd1);
  endtask

  // App sources: present queue head, pop on a handshake seen at the edge.
  always @(posedge clk) begin
    logic [N-1:0] f;
    logic [W:0]   h;
    f = req_valid & req_ready;
    #1;
    if (!man) begin
      for (int i = 0; i < N; i++) begin
        if (f[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          h = src_q[i][0];
          req_valid[i] = 1'b1;
          req_last[i]  = h[W];
          req_data[i*W +: W] = h[W-1:0];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
          req_data[i*W +: W] = '0;
        end
      end
    end
  end

  // Write monitor against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (wr_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_wr", {16'h0, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_id", 64'(wr_app_id), 64'(e.id));
          chk("wr_data", 64'(wr_data), 64'(e.data));
          chk("wr_burst_err", 64'(burst_err), 64'(e.err));
        end
      end else if (burst_err) begin
        chk("stray_burst_err", 64'(burst_err), 64'd0);
      end
      if (track2 && req_ready[2]) seen2 = 1'b1;
      if (track1 && req_ready[1]) seen1 = 1'b1;
    end
  end

  initial begin
    man       = 1'b1;
    track1    = 1'b0;
    track2    = 1'b0;
    seen1     = 1'b0;
    seen2     = 1'b0;
    rstn      = 1'b0;
    app_en    = '1;
    fifo_full = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = {N{48'h1234_5678_9ABC}};

    // 1: reset holds everything quiet despite requests
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
    end
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    man       = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // 2: single app2 packet A,B,C
    push_src(2, mk(2, 1), 1'b0);
    push_src(2, mk(2, 2), 1'b0);
    push_src(2, mk(2, 3), 1'b1);
    expect_wr(2, mk(2, 1), 1'b0);
    expect_wr(2, mk(2, 2), 1'b0);
    expect_wr(2, mk(2, 3), 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk($sformatf("t2_ready2_c%0d", k), 64'(req_ready[2]),
          64'(k >= 2 && k <= 4));
      chk($sformatf("t2_wr_en_c%0d", k), 64'(wr_en),
          64'(k >= 3 && k <= 5));
      chk($sformatf("t2_busy_c%0d", k), 64'(busy),
          64'(k >= 2 && k <= 4));
    end
    drain("t2");

    // 3: rr_ptr now 3, so order is 3,0,1,3,0,1; app2 idle
    track2 = 1'b1;
    seen2  = 1'b0;
    for (int r = 0; r < 2; r++) begin
      push_src(0, mk(0, 10 + r), 1'b1);
      push_src(1, mk(1, 10 + r), 1'b1);
      push_src(3, mk(3, 10 + r), 1'b1);
    end
    for (int r = 0; r < 2; r++) begin
      expect_wr(3, mk(3, 10 + r), 1'b0);
      expect_wr(0, mk(0, 10 + r), 1'b0);
      expect_wr(1, mk(1, 10 + r), 1'b0);
    end
    drain("t3");
    chk("t3_app2_never", 64'(seen2), 64'd0);
    track2 = 1'b0;

    // 4: backpressure for 5 cycles after the first word
    push_src(0, mk(0, 20), 1'b0);
    push_src(0, mk(0, 21), 1'b0);
    push_src(0, mk(0, 22), 1'b1);
    expect_wr(0, mk(0, 20), 1'b0);
    expect_wr(0, mk(0, 21), 1'b0);
    expect_wr(0, mk(0, 22), 1'b0);
    repeat (3) @(negedge clk);
    chk("t4_first_wr", 64'(wr_en), 64'd1);
    fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_bp_ready", 64'(req_ready), 64'd0);
      chk("t4_bp_wr_en", 64'(wr_en), 64'd0);
      chk("t4_bp_busy", 64'(busy), 64'd1);
    end
    fifo_full = 1'b0;
    drain("t4");

    // 5: app1 runaway cut at 4 words; app3 waiting gets the next grant
    for (int k = 0; k < 6; k++) push_src(1, mk(1, 30 + k), 1'b0);
    push_src(3, mk(3, 30), 1'b1);
    for (int k = 0; k < 4; k++) expect_wr(1, mk(1, 30 + k), k == 3);
    expect_wr(3, mk(3, 30), 1'b0);
    expect_wr(1, mk(1, 34), 1'b0);
    expect_wr(1, mk(1, 35), 1'b0);
    repeat (30) @(negedge clk);
    chk("t5_pending", 64'(sb.size()), 64'd0);
    chk("t5_grant_held", 64'(busy), 64'd1);
    push_src(1, mk(1, 36), 1'b1);
    push_src(0, mk(0, 30), 1'b1);
    expect_wr(1, mk(1, 36), 1'b0);
    expect_wr(0, mk(0, 30), 1'b0);
    drain("t5");

    // 6: disable app1 mid-packet; packet completes, then app1 starves
    push_src(1, mk(1, 40), 1'b0);
    push_src(1, mk(1, 41), 1'b0);
    push_src(1, mk(1, 42), 1'b1);
    expect_wr(1, mk(1, 40), 1'b0);
    expect_wr(1, mk(1, 41), 1'b0);
    expect_wr(1, mk(1, 42), 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_first_wr", 64'(wr_en), 64'd1);
    app_en[1] = 1'b0;
    drain("t6a");
    track1 = 1'b1;
    seen1  = 1'b0;
    push_src(1, mk(1, 43), 1'b1);
    push_src(3, mk(3, 40), 1'b1);
    expect_wr(3, mk(3, 40), 1'b0);
    repeat (20) @(negedge clk);
    chk("t6_pending", 64'(sb.size()), 64'd0);
    chk("t6_app1_waiting", 64'(src_q[1].size()), 64'd1);
    chk("t6_app1_no_ready", 64'(seen1), 64'd0);
    chk("t6_idle", 64'(busy), 64'd0);
    track1 = 1'b0;
    app_en[1] = 1'b1;
    expect_wr(1, mk(1, 43), 1'b0);
    drain("t6b");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
